writeback_merge: RTL and testbench
==================================

WRITEBACK_MERGE -- requirements
Module: writeback_merge

Interface
REQ-001 Parameter: DEPTH, default 4, long-latency result FIFO entries; power of two, 2 to 16.
REQ-002 Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
REQ-003 clk  in  1  clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 p1_valid / p1_addr / p1_data  in  1/5/32  pipe-1 writeback result; always accepted.
REQ-006 p2_valid / p2_addr / p2_data  in  1/5/32  pipe-2 writeback result; younger than pipe 1; always accepted.
REQ-007 lu_valid / lu_addr / lu_data  in  1/5/32  long-latency (mul/div/miss-load) result offer.
REQ-008 lu_ready  out  1  FIFO can accept an lu result this cycle.
REQ-009 Write_Enable_1 / Write_Addr_1 / Write_Data_1  out  1/5/32  register-file write port 1 (registered).
REQ-010 Write_Enable_2 / Write_Addr_2 / Write_Data_2  out  1/5/32  register-file write port 2 (registered).
REQ-011 fifo_count  out  clog2(DEPTH)+1  occupied FIFO entries, including killed entries.

Function
REQ-012 The block SHALL treat any pipe result with addr 0 as not valid.
REQ-013 An lu result with addr 0 SHALL be accepted and discarded, not enqueued.
REQ-014 An lu transfer SHALL occur when lu_valid && lu_ready.
REQ-015 lu_ready SHALL equal (fifo_count < DEPTH) && !reset, with no dependency on same-cycle pops.
REQ-016 All write-port outputs SHALL be registered: inputs in cycle N appear on the write ports in cycle N+1.
REQ-017 Valid p1 SHALL map to port 1 and valid p2 to port 2.
REQ-018 If p1 and p2 are both valid with equal addr, port 1 SHALL be suppressed, p2 written, and port 1 counted free.
REQ-019 Free ports SHALL be filled from the FIFO head in order: head to the lowest-numbered free port, next entry to the next free port.
REQ-020 The FIFO SHALL pop at most 2 entries per cycle.
REQ-021 An entry accepted in cycle N SHALL be drain-eligible no earlier than cycle N+1; there is no same-cycle bypass.
REQ-022 Kill rule: a valid pipe write in cycle N to address A SHALL clear the live bit of every FIFO entry holding A.
REQ-023 Kill rule: an lu result transferred in cycle N to address A SHALL be enqueued with its live bit clear.
REQ-024 A killed head entry SHALL pop without occupying a port; it counts toward the 2-pop limit.
REQ-025 Simultaneous enqueue and pops in one cycle SHALL update fifo_count by (+push - pops).
REQ-026 Read/write pointers SHALL wrap modulo DEPTH.
REQ-027 Full FIFO: lu_ready=0, and no entry is lost or overwritten.
REQ-028 Empty FIFO: free ports SHALL drive Write_Enable_x=0, with addr and data held at 0.
REQ-029 The two write ports SHALL never carry equal non-zero addresses with both enables set in the same cycle.

Reset
REQ-030 While reset=1 at a clk edge: Write_Enable_1/2=0, Write_Addr_1/2=0, Write_Data_1/2=0, FIFO emptied (fifo_count=0), all live bits cleared.
REQ-031 Reset asserted mid-operation SHALL discard all queued lu results; any lu offer in that cycle SHALL NOT transfer.
REQ-032 The first accepted transfer after reset SHALL occur in the first cycle with reset=0.

Configuration
REQ-033 Macro WB_STALL_CNT_EN, when defined, SHALL add output lu_stall_cnt (out, 32): counts cycles with lu_valid && !lu_ready.
REQ-034 lu_stall_cnt SHALL clear on reset and wrap at 2^32.
REQ-035 With WB_STALL_CNT_EN undefined, neither the port nor the counter SHALL exist, and all other behaviour is identical.

Verification
REQ-036 Scenario 1: p1 (5, 0x11), p2 (6, 0x22) in cycle 0 -> cycle 1: WE1=1 addr 5 data 0x11, WE2=1 addr 6 data 0x22.
REQ-037 Scenario 2: p1 and p2 both to addr 7 (0xAA, 0xBB) -> cycle 1: WE1=0, WE2=1 addr 7 data 0xBB.
REQ-038 Scenario 3: lu pushes 4 entries with both pipes busy -> fifo_count=4 and lu_ready=0; pipes idle -> two writes per cycle in push order, FIFO empty after 2 cycles.
REQ-039 Scenario 4: lu enqueues (9, 0x99); next cycle p1 writes (9, 0x55) with p2 idle -> only (9, 0x55) is written, the killed entry pops without a write, and fifo_count=0.
REQ-040 Scenario 5: reset asserted with 3 queued entries -> next cycle fifo_count=0, all WE=0; WB_STALL_CNT_EN build: 10 stalled cycles -> lu_stall_cnt=10.

Source files
------------

// File: rtl/writeback_merge.sv
// Writeback merge: two pipe results plus a long-latency FIFO onto two RF ports.
// Optional WB_STALL_CNT_EN adds lu_stall_cnt, a count of cycles an lu offer is refused.
module writeback_merge #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p1_valid,
  input  logic [4:0]              p1_addr,
  input  logic [31:0]             p1_data,
  input  logic                    p2_valid,
  input  logic [4:0]              p2_addr,
  input  logic [31:0]             p2_data,
  input  logic                    lu_valid,
  input  logic [4:0]              lu_addr,
  input  logic [31:0]             lu_data,
  output logic                    lu_ready,
  output logic                    Write_Enable_1,
  output logic [4:0]              Write_Addr_1,
  output logic [31:0]             Write_Data_1,
  output logic                    Write_Enable_2,
  output logic [4:0]              Write_Addr_2,
  output logic [31:0]             Write_Data_2,
  output logic [$clog2(DEPTH):0]  fifo_count
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]             lu_stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_p1v;
  logic             w_p2v;
  logic             w_p1w;
  logic             w_push;
  logic             w_lu_kill;
  logic [DEPTH-1:0] w_elive;
  logic [1:0]       w_pop;
  logic             w_stop;
  logic             w_hit;
  logic [4:0]       w_last;
  logic [PW-1:0]    w_idx;
  logic             w_we1;
  logic [4:0]       w_wa1;
  logic [31:0]      w_wd1;
  logic             w_we2;
  logic [4:0]       w_wa2;
  logic [31:0]      w_wd2;

  assign w_p1v     = p1_valid && (p1_addr != 5'd0);
  assign w_p2v     = p2_valid && (p2_addr != 5'd0);
  // p2 is younger, so it wins a same-address collision
  assign w_p1w     = w_p1v && !(w_p2v && (p1_addr == p2_addr));
  assign lu_ready  = (r_count < LP_DEPTH) && !reset;
  assign w_push    = lu_valid && lu_ready && (lu_addr != 5'd0);
  assign w_lu_kill = (w_p1v && (lu_addr == p1_addr)) ||
                     (w_p2v && (lu_addr == p2_addr));
  assign fifo_count = r_count;

  // Live bits after this cycle's pipe writes kill matching entries
  always_comb begin
    w_elive = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_elive[i] = r_live[i] &&
        !(w_p1v && (r_addr[i] == p1_addr)) &&
        !(w_p2v && (r_addr[i] == p2_addr));
    end
  end

  // Port selection: pipes first, then in-order FIFO drain into free ports
  always_comb begin
    w_we1  = w_p1w;
    w_wa1  = w_p1w ? p1_addr : 5'd0;
    w_wd1  = w_p1w ? p1_data : 32'd0;
    w_we2  = w_p2v;
    w_wa2  = w_p2v ? p2_addr : 5'd0;
    w_wd2  = w_p2v ? p2_data : 32'd0;
    w_pop  = 2'd0;
    w_stop = 1'b0;
    w_hit  = 1'b0;
    w_last = 5'd0;
    w_idx  = r_rd_ptr;
    for (int k = 0; k < 2; k++) begin
      w_idx = r_rd_ptr + PW'(k);
      if (!w_stop && (r_count > CW'(k))) begin
        if (!w_elive[w_idx]) begin
          w_pop = w_pop + 2'd1;
        end else if (w_hit && (r_addr[w_idx] == w_last)) begin
          // never drive one address on both ports; it waits a cycle
          w_stop = 1'b1;
        end else if (!w_we1) begin
          w_we1  = 1'b1;
          w_wa1  = r_addr[w_idx];
          w_wd1  = r_data[w_idx];
          w_hit  = 1'b1;
          w_last = r_addr[w_idx];
          w_pop  = w_pop + 2'd1;
        end else if (!w_we2) begin
          w_we2  = 1'b1;
          w_wa2  = r_addr[w_idx];
          w_wd2  = r_data[w_idx];
          w_hit  = 1'b1;
          w_last = r_addr[w_idx];
          w_pop  = w_pop + 2'd1;
        end else begin
          w_stop = 1'b1;
        end
      end
    end
  end

  // FIFO state and registered write ports
  always_ff @(posedge clk) begin
    if (reset) begin
      r_live         <= '0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      Write_Enable_1 <= 1'b0;
      Write_Addr_1   <= 5'd0;
      Write_Data_1   <= 32'd0;
      Write_Enable_2 <= 1'b0;
      Write_Addr_2   <= 5'd0;
      Write_Data_2   <= 32'd0;
    end else begin
      r_live <= w_elive;
      if (w_push) begin
        r_addr[r_wr_ptr] <= lu_addr;
        r_data[r_wr_ptr] <= lu_data;
        r_live[r_wr_ptr] <= !w_lu_kill;
      end
      r_wr_ptr       <= r_wr_ptr + PW'(w_push);
      r_rd_ptr       <= r_rd_ptr + PW'(w_pop);
      r_count        <= r_count + CW'(w_push) - CW'(w_pop);
      Write_Enable_1 <= w_we1;
      Write_Addr_1   <= w_wa1;
      Write_Data_1   <= w_wd1;
      Write_Enable_2 <= w_we2;
      Write_Addr_2   <= w_wa2;
      Write_Data_2   <= w_wd2;
    end
  end

`ifdef WB_STALL_CNT_EN
  // Cycles where an lu result is offered but refused
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_stall_cnt <= 32'd0;
    end else if (lu_valid && !lu_ready) begin
      lu_stall_cnt <= lu_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_merge.sv
// Scoreboard bench for writeback_merge: queue-level reference model,
// directed scenarios then randomized traffic, checked by a monitor process.
module tb_writeback_merge;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p1_valid = 1'b0;
  logic [4:0]  p1_addr = '0;
  logic [31:0] p1_data = '0;
  logic        p2_valid = 1'b0;
  logic [4:0]  p2_addr = '0;
  logic [31:0] p2_data = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_addr = '0;
  logic [31:0] lu_data = '0;
  logic        lu_ready;
  logic        we1, we2;
  logic [4:0]  wa1, wa2;
  logic [31:0] wd1, wd2;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef WB_STALL_CNT_EN
  logic [31:0] lu_stall_cnt;
`endif

  writeback_merge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_data(p1_data),
    .p2_valid(p2_valid), .p2_addr(p2_addr), .p2_data(p2_data),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data),
    .lu_ready(lu_ready),
    .Write_Enable_1(we1), .Write_Addr_1(wa1), .Write_Data_1(wd1),
    .Write_Enable_2(we2), .Write_Addr_2(wa2), .Write_Data_2(wd2),
    .fifo_count(fifo_count)
`ifdef WB_STALL_CNT_EN
    , .lu_stall_cnt(lu_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  typedef struct {
    bit          we1;
    logic [4:0]  a1;
    logic [31:0] d1;
    bit          we2;
    logic [4:0]  a2;
    logic [31:0] d2;
    int          cnt;
    int unsigned stall;
  } exp_t;

  ent_t q[$];
  exp_t eq[$];
  int unsigned stall_m = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model
  task automatic step(input bit rst,
                      input bit v1i, input logic [4:0] a1i, input logic [31:0] d1i,
                      input bit v2i, input logic [4:0] a2i, input logic [31:0] d2i,
                      input bit vl, input logic [4:0] al, input logic [31:0] dl);
    exp_t e;
    bit   rdy, v1, v2;
    int   pops;
    logic [4:0] last;
    @(negedge clk);
    reset = rst;
    p1_valid = v1i; p1_addr = a1i; p1_data = d1i;
    p2_valid = v2i; p2_addr = a2i; p2_data = d2i;
    lu_valid = vl;  lu_addr = al;  lu_data = dl;
    #1;
    rdy = !rst && (q.size() < DEPTH);
    chk("lu_ready", {31'd0, lu_ready}, {31'd0, rdy});
    e = '{we1: 0, a1: 0, d1: 0, we2: 0, a2: 0, d2: 0, cnt: 0, stall: 0};
    if (rst) begin
      q.delete();
      stall_m = 0;
    end else begin
      if (vl && !rdy) stall_m++;
      v1 = v1i && (a1i != 0);
      v2 = v2i && (a2i != 0);
      foreach (q[i])
        if ((v1 && q[i].a == a1i) || (v2 && q[i].a == a2i)) q[i].live = 0;
      if (v1 && !(v2 && a1i == a2i)) begin
        e.we1 = 1; e.a1 = a1i; e.d1 = d1i;
      end
      if (v2) begin
        e.we2 = 1; e.a2 = a2i; e.d2 = d2i;
      end
      pops = 0;
      last = 0;
      while (pops < 2 && q.size() > 0) begin
        if (!q[0].live) begin
          void'(q.pop_front());
          pops++;
        end else if (q[0].a == last) begin
          break;
        end else if (!e.we1) begin
          e.we1 = 1; e.a1 = q[0].a; e.d1 = q[0].d;
          last = q[0].a;
          void'(q.pop_front());
          pops++;
        end else if (!e.we2) begin
          e.we2 = 1; e.a2 = q[0].a; e.d2 = q[0].d;
          last = q[0].a;
          void'(q.pop_front());
          pops++;
        end else begin
          break;
        end
      end
      if (vl && rdy && al != 0)
        q.push_back('{a: al, d: dl,
                      live: !((v1 && al == a1i) || (v2 && al == a2i))});
    end
    e.cnt = q.size();
    e.stall = stall_m;
    eq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare registered outputs just after each edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (eq.size() > 0) begin
      e = eq.pop_front();
      chk("we1", {31'd0, we1}, {31'd0, e.we1});
      chk("addr1", {27'd0, wa1}, {27'd0, e.a1});
      chk("data1", wd1, e.d1);
      chk("we2", {31'd0, we2}, {31'd0, e.we2});
      chk("addr2", {27'd0, wa2}, {27'd0, e.a2});
      chk("data2", wd2, e.d2);
      chk("fifo_count", 32'(fifo_count), 32'(e.cnt));
      if (we1 && we2 && wa1 != 0)
        chk("port_collision", {27'd0, wa1 ^ wa2} == 0 ? 32'd1 : 32'd0, 32'd0);
`ifdef WB_STALL_CNT_EN
      chk("lu_stall_cnt", lu_stall_cnt, e.stall);
`endif
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33);
    // Scenario 1: independent pipe writes
    step(0, 1, 5, 32'h11, 1, 6, 32'h22, 0, 0, 0);
    // Scenario 2: same-address collision, p2 wins
    step(0, 1, 7, 32'hAA, 1, 7, 32'hBB, 0, 0, 0);
    // Scenario 3: fill with pipes busy, then drain two per cycle
    for (int i = 0; i < 4; i++)
      step(0, 1, 20, i, 1, 21, i, 1, 5'(i + 1), 32'h100 + i);
    step(0, 1, 20, 9, 1, 21, 9, 1, 12, 32'hDEAD);
    idle(3);
    // Scenario 4: pipe write kills queued entry
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99);
    step(0, 1, 9, 32'h55, 0, 0, 0, 0, 0, 0);
    idle(1);
    // lu addr 0 is swallowed; lu killed on arrival
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1);
    step(0, 0, 0, 0, 1, 4, 32'h44, 1, 4, 32'h45);
    idle(2);
    // Scenario 5: reset with 3 queued entries
    for (int i = 0; i < 3; i++)
      step(0, 1, 20, 0, 1, 21, 0, 1, 5'(i + 1), i);
    step(1, 1, 20, 0, 1, 21, 0, 1, 8, 8);
    step(0, 0, 0, 0, 0, 0, 0, 1, 10, 32'h10);
    idle(2);
    // Stall run: 10 refused offers with pipes busy
    for (int i = 0; i < 14; i++)
      step(0, 1, 20, 0, 1, 21, 0, 1, 5'(i % 7 + 1), i);
    idle(3);
    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom);
    end
    idle(4);
    repeat (4) @(posedge clk);
    #3;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results never checked", eq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
